// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM learn controller and the CAM.
package cam_pkg;

    localparam int CAM_DATA_WIDTH = 32;
    localparam int CAM_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOOKUP,
        ST_LEARN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cam_alloc.sv
// Round-robin allocation pointer and saturating count of learned entries.
module cam_alloc
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] alloc_ptr,
    output logic [ADDR_WIDTH:0]   learn_count
);

    // The top bit of learn_count alone marks a full table.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            alloc_ptr   <= '0;
            learn_count <= '0;
        end else if (advance) begin
            alloc_ptr <= alloc_ptr + 1'b1;
            if (!learn_count[ADDR_WIDTH])
                learn_count <= learn_count + 1'b1;
        end
    end

endmodule

// File: rtl/cam_learn_ctrl.sv
// Lookup/learn/flush sequencer driving an external CAM's write and search ports.
module cam_learn_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_key,
    input  logic                  req_learn,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_learned,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  cam_we,
    output logic [ADDR_WIDTH-1:0] cam_addr,
    output logic [DATA_WIDTH-1:0] cam_data,
    output logic                  cam_valid,
    output logic [DATA_WIDTH-1:0] lookup_data,
    input  logic                  lookup_hit,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic [ADDR_WIDTH:0]   learn_count
);

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] key_q;
    logic                  learn_q;
    logic                  flush_pend;
    logic [ADDR_WIDTH-1:0] flush_idx;
    logic                  hit_q;
    logic                  learned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] alloc_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  flush_go;
    logic                  flush_done;
    logic                  accept;

    assign flush_go   = flush | flush_pend;
    assign flush_done = (state == ST_FLUSH) && (&flush_idx);
    assign accept     = (state == ST_IDLE) && !flush_go && req_valid;

    cam_alloc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_alloc (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush_done),
        .advance    (state == ST_LEARN),
        .alloc_ptr  (alloc_ptr),
        .learn_count(count)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FLUSH:  if (&flush_idx) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (flush_go)       state_nx = ST_FLUSH;
                else if (req_valid) state_nx = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!lookup_hit && learn_q) state_nx = ST_LEARN;
                else                        state_nx = ST_RESP;
            end
            ST_LEARN:  state_nx = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_FLUSH;
        endcase
    end

    // Every output is forced low while reset is held.
    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_hit     = 1'b0;
        rsp_learned = 1'b0;
        rsp_addr    = '0;
        cam_we      = 1'b0;
        cam_addr    = '0;
        cam_data    = '0;
        cam_valid   = 1'b0;
        lookup_data = '0;
        learn_count = '0;
        if (!reset) begin
            lookup_data = key_q;
            learn_count = count;
            rsp_hit     = hit_q;
            rsp_learned = learned_q;
            rsp_addr    = addr_q;
            unique case (state)
                ST_IDLE:  req_ready = 1'b1;
                ST_FLUSH: begin
                    cam_we   = 1'b1;
                    cam_addr = flush_idx;
                end
                ST_LEARN: begin
                    cam_we    = 1'b1;
                    cam_valid = 1'b1;
                    cam_addr  = alloc_ptr;
                    cam_data  = key_q;
                end
                ST_RESP:  rsp_valid = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            key_q      <= '0;
            learn_q    <= 1'b0;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
            hit_q      <= 1'b0;
            learned_q  <= 1'b0;
            addr_q     <= '0;
        end else begin
            state <= state_nx;
            if (flush && state != ST_IDLE)
                flush_pend <= 1'b1;
            if (state == ST_FLUSH) begin
                flush_idx <= flush_idx + 1'b1;
                if (&flush_idx)
                    flush_pend <= 1'b0;
            end
            if (accept) begin
                key_q   <= req_key;
                learn_q <= req_learn;
            end
            if (state == ST_LOOKUP) begin
                hit_q     <= lookup_hit;
                learned_q <= 1'b0;
                addr_q    <= lookup_hit ? lookup_addr : '0;
            end
            if (state == ST_LEARN) begin
                hit_q     <= 1'b0;
                learned_q <= 1'b1;
                addr_q    <= alloc_ptr;
            end
        end
    end

endmodule
